// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution scheduler.
//   conv_state_t : scheduler FSM states
//   TAP_*        : 9-bit masks of window taps (bit i = tap i, row-major)
//                  that fall outside the image on each border
//   CNT_W()      : bits needed for a counter spanning 0..n-1
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } conv_state_t;

  localparam logic [8:0] TAP_TOP    = 9'b000_000_111;
  localparam logic [8:0] TAP_BOTTOM = 9'b111_000_000;
  localparam logic [8:0] TAP_LEFT   = 9'b001_001_001;
  localparam logic [8:0] TAP_RIGHT  = 9'b100_100_100;

  function automatic int CNT_W(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: valid/last tag shift register that runs alongside the MAC
// pipeline registers, so the tags emerge with the result they describe.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : shift enable (same enable as the MAC registers)
//   in_valid, in_last   : tag of the window entering the MAC pipeline
//   out_valid, out_last : tag of the result at the pipeline output
//   any_valid           : some stage still holds a valid tag
module conv_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic any_valid
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_reg[i] <= valid_reg[i-1];
        last_reg[i]  <= last_reg[i-1];
      end
      valid_reg[0] <= in_valid;
      // last is meaningless without valid; gating keeps m_last clean
      last_reg[0]  <= in_valid & in_last;
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_last  = last_reg[DEPTH-1];
  assign any_valid = |valid_reg;

endmodule

// File: rtl/conv3x3_scheduler.sv
// conv3x3_scheduler: sequencing controller for the 3x3 convolution datapath.
// Loads nine kernel coefficients, paces a raster pixel stream into the
// external line buffers/window, appends IMG_W+1 zero flush shifts, produces
// per-centre zero-padding masks and tags the MAC pipeline output.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : frame start pulse (IDLE only)
//   k_valid/k_ready    : kernel word handshake, k_in row-major k00..k22
//   k_data             : held coefficients, k00 in LSBs
//   s_valid/s_ready    : pixel input handshake
//   shift_en, pad_in   : advance window one pixel / push zero (flush)
//   win_valid,pad_mask : window holds a real centre / taps to zero
//   mac_ce             : MAC pipeline clock enable
//   m_valid/m_ready    : result handshake, m_last marks final pixel
//   done               : one-cycle frame completion pulse
module conv3x3_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W        = 64,
  parameter int IMG_H        = 64,
  parameter int KERNEL_WIDTH = 16,
  parameter int MAC_LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      k_valid,
  output logic                      k_ready,
  input  logic [KERNEL_WIDTH-1:0]   k_in,
  output logic [9*KERNEL_WIDTH-1:0] k_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      shift_en,
  output logic                      pad_in,
  output logic                      win_valid,
  output logic [8:0]                pad_mask,
  output logic                      mac_ce,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int TW   = CNT_W(NPIX + IMG_W + 2);
  localparam int RW   = CNT_W(IMG_H);
  localparam int CW   = CNT_W(IMG_W);

  localparam logic [TW-1:0] LAST_PIX     = TW'(NPIX - 1);
  localparam logic [TW-1:0] LAST_FLUSH   = TW'(NPIX + IMG_W);
  // the window centre trails the input by one row plus one pixel
  localparam logic [TW-1:0] CENTRE_START = TW'(IMG_W + 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);

  conv_state_t             state_reg;
  logic [3:0]              k_idx_reg;
  logic [KERNEL_WIDTH-1:0] k_regs [9];
  logic                    k_ready_reg;
  logic                    done_reg;
  logic [TW-1:0]           tick_cnt_reg;
  logic [RW-1:0]           cr_reg;
  logic [CW-1:0]           cc_reg;
  logic                    win_valid_reg;
  logic [8:0]              pad_mask_reg;
  logic                    win_new_reg;
  logic                    win_last_reg;

  logic       stall;
  logic       k_fire;
  logic       centre_tick;
  logic       last_centre;
  logic       pipe_busy;
  logic [8:0] mask_next;

  assign stall    = m_valid & ~m_ready;
  assign mac_ce   = ~stall;
  assign s_ready  = (state_reg == ST_RUN) & ~stall;
  assign pad_in   = (state_reg == ST_FLUSH) & ~stall;
  assign shift_en = (s_valid & s_ready) | pad_in;
  assign k_fire   = k_ready_reg & k_valid;

  assign centre_tick = shift_en & (tick_cnt_reg >= CENTRE_START);
  assign last_centre = (cr_reg == ROW_LAST) && (cc_reg == COL_LAST);

  assign k_ready   = k_ready_reg;
  assign done      = done_reg;
  assign win_valid = win_valid_reg;
  assign pad_mask  = pad_mask_reg;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_kpack
      assign k_data[gi*KERNEL_WIDTH +: KERNEL_WIDTH] = k_regs[gi];
    end
  endgenerate

  always_comb begin
    mask_next = '0;
    if (cr_reg == '0)      mask_next = mask_next | TAP_TOP;
    if (cr_reg == ROW_LAST) mask_next = mask_next | TAP_BOTTOM;
    if (cc_reg == '0)      mask_next = mask_next | TAP_LEFT;
    if (cc_reg == COL_LAST) mask_next = mask_next | TAP_RIGHT;
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      k_idx_reg   <= '0;
      k_ready_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg   <= ST_LOAD_K;
            k_idx_reg   <= '0;
            k_ready_reg <= 1'b1;
          end
        end
        ST_LOAD_K: begin
          if (k_fire) begin
            if (k_idx_reg == 4'd8) begin
              state_reg   <= ST_RUN;
              k_ready_reg <= 1'b0;
            end else begin
              k_idx_reg <= k_idx_reg + 4'd1;
            end
          end
        end
        ST_RUN: begin
          if (shift_en && tick_cnt_reg == LAST_PIX) state_reg <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (shift_en && tick_cnt_reg == LAST_FLUSH) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pipe_busy) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg   <= ST_IDLE;
          k_ready_reg <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient store: held until the next load overwrites it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) k_regs[i] <= '0;
    end else if (state_reg == ST_LOAD_K && k_fire) begin
      k_regs[k_idx_reg] <= k_in;
    end
  end

  // Tick and centre counters, window tag and padding mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg  <= '0;
      cr_reg        <= '0;
      cc_reg        <= '0;
      win_valid_reg <= 1'b0;
      pad_mask_reg  <= '0;
    end else if (state_reg == ST_LOAD_K) begin
      tick_cnt_reg  <= '0;
      cr_reg        <= '0;
      cc_reg        <= '0;
      win_valid_reg <= 1'b0;
      pad_mask_reg  <= '0;
    end else if (shift_en) begin
      tick_cnt_reg  <= tick_cnt_reg + 1'b1;
      win_valid_reg <= centre_tick;
      if (centre_tick) begin
        pad_mask_reg <= mask_next;
        if (cc_reg == COL_LAST) begin
          cc_reg <= '0;
          cr_reg <= (cr_reg == ROW_LAST) ? '0 : cr_reg + 1'b1;
        end else begin
          cc_reg <= cc_reg + 1'b1;
        end
      end
    end
  end

  // A fresh window is offered to the MAC pipe exactly once: the flag holds
  // through a stall and is consumed by the first enabled MAC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_new_reg  <= 1'b0;
      win_last_reg <= 1'b0;
    end else if (!stall) begin
      win_new_reg  <= centre_tick;
      win_last_reg <= centre_tick & last_centre;
    end
  end

  logic tag_any;

  conv_tag_pipe #(
    .DEPTH (MAC_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (mac_ce),
    .in_valid  (win_new_reg),
    .in_last   (win_last_reg),
    .out_valid (m_valid),
    .out_last  (m_last),
    .any_valid (tag_any)
  );

  assign pipe_busy = tag_any | win_new_reg;

endmodule

// File: tb/tb_conv3x3_scheduler.sv
// Testbench for conv3x3_scheduler with a 4x3 image. A monitor predicts the
// window centre, pad mask and m_last of every tick and queues the expected
// result tags, which are popped as the DUT hands results out.
module tb_conv3x3_scheduler;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int KW = 16;
  localparam int ML = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          k_valid;
  logic          k_ready;
  logic [KW-1:0] k_in;
  logic [9*KW-1:0] k_data;
  logic          s_valid;
  logic          s_ready;
  logic          shift_en;
  logic          pad_in;
  logic          win_valid;
  logic [8:0]    pad_mask;
  logic          mac_ce;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          done;

  int checks = 0;
  int errors = 0;
  int out_total = 0;
  int done_total = 0;
  int cyc = 0;

  conv3x3_scheduler #(
    .IMG_W        (W),
    .IMG_H        (H),
    .KERNEL_WIDTH (KW),
    .MAC_LATENCY  (ML)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_valid   (k_valid),
    .k_ready   (k_ready),
    .k_in      (k_in),
    .k_data    (k_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .shift_en  (shift_en),
    .pad_in    (pad_in),
    .win_valid (win_valid),
    .pad_mask  (pad_mask),
    .mac_ce    (mac_ce),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic chk_rst_vals(input string pfx);
    chk({pfx, "_k_ready"},   32'(k_ready), 0);
    chk({pfx, "_s_ready"},   32'(s_ready), 0);
    chk({pfx, "_shift_en"},  32'(shift_en), 0);
    chk({pfx, "_pad_in"},    32'(pad_in), 0);
    chk({pfx, "_win_valid"}, 32'(win_valid), 0);
    chk({pfx, "_pad_mask"},  32'(pad_mask), 0);
    chk({pfx, "_mac_ce"},    32'(mac_ce), 1);
    chk({pfx, "_m_valid"},   32'(m_valid), 0);
    chk({pfx, "_m_last"},    32'(m_last), 0);
    chk({pfx, "_done"},      32'(done), 0);
    chk({pfx, "_k_data"},    32'(|k_data), 0);
  endtask

  // Monitor / scoreboard
  initial begin
    int   tick_no;
    bit   pend;
    bit   pend_centre;
    int   pend_idx;
    logic [8:0] pend_mask;
    bit   exp_q[$];
    int   last_cyc;
    tick_no = 0;
    pend = 0;
    pend_centre = 0;
    pend_idx = 0;
    pend_mask = '0;
    last_cyc = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        tick_no = 0;
        pend = 0;
        exp_q.delete();
      end else begin
        if (pend) begin
          chk("win_valid", 32'(win_valid), 32'(pend_centre));
          if (pend_centre) begin
            chk("pad_mask", 32'(pad_mask), 32'(pend_mask));
            if (pend_idx == 0)  chk("mask_c00", 32'(pad_mask), 32'h04F);
            if (pend_idx == 5)  chk("mask_c11", 32'(pad_mask), 32'h000);
            if (pend_idx == 11) chk("mask_c23", 32'(pad_mask), 32'h1E4);
          end
          pend = 0;
        end
        if (m_valid && m_ready) begin
          out_total++;
          if (exp_q.size() == 0) begin
            chk("m_extra", 1, 0);
          end else begin
            bit e;
            e = exp_q.pop_front();
            chk("m_last", 32'(m_last), 32'(e));
            if (e) last_cyc = cyc;
          end
        end
        if (done) begin
          done_total++;
          chk("done_lat", 32'(cyc - last_cyc), 2);
          chk("q_empty", 32'(exp_q.size()), 0);
          tick_no = 0;
        end
        if (shift_en) begin
          tick_no++;
          chk("pad_in", 32'(pad_in), 32'(tick_no > W * H));
          pend = 1;
          if (tick_no >= W + 2) begin
            int r;
            int c;
            pend_idx = tick_no - (W + 2);
            r = pend_idx / W;
            c = pend_idx % W;
            for (int b = 0; b < 9; b++) begin
              pend_mask[b] = ((b / 3 == 0) && r == 0) || ((b / 3 == 2) && r == H - 1) ||
                             ((b % 3 == 0) && c == 0) || ((b % 3 == 2) && c == W - 1);
            end
            pend_centre = 1;
            exp_q.push_back(r == H - 1 && c == W - 1);
          end else begin
            pend_centre = 0;
          end
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_kernel(input int base);
    for (int i = 0; i < 9; i++) begin
      chk("k_ready", 32'(k_ready), 1);
      if (i == 8) chk("run_early", 32'(s_ready), 0);
      k_valid = 1'b1;
      k_in = KW'(base + i);
      @(posedge clk); #1;
      k_valid = 1'b0;
      if (i < 8) begin
        @(posedge clk); #1;
      end
    end
    chk("run_after9", 32'(s_ready), 1);
    chk("k_ready_off", 32'(k_ready), 0);
    for (int j = 0; j < 9; j++) chk("k_data", 32'(k_data[j*KW +: KW]), 32'(base + j));
  endtask

  task automatic wait_done(input int db);
    for (int n = 0; n < 300 && done_total == db; n++) @(negedge clk);
    if (done_total == db) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int ob;
    int db;
    logic held_last;
    rst_n = 1'b0;
    start = 1'b0;
    k_valid = 1'b0;
    k_in = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    held_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame 1: kernel with gaps, spurious start/k_valid in RUN, backpressure
    ob = out_total;
    db = done_total;
    do_start();
    load_kernel(1);
    s_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    k_valid = 1'b1;
    k_in = 16'hABCD;
    repeat (2) begin
      @(posedge clk); #1;
      chk("run_k_ready", 32'(k_ready), 0);
      chk("run_s_ready", 32'(s_ready), 1);
    end
    start = 1'b0;
    k_valid = 1'b0;
    for (int j = 0; j < 9; j++) chk("k_hold", 32'(k_data[j*KW +: KW]), 32'(1 + j));

    for (int n = 0; n < 100 && out_total < ob + 3; n++) @(negedge clk);
    chk("bp_reach", 32'(out_total - ob >= 3), 1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n == 0) held_last = m_last;
      chk("bp_s_ready", 32'(s_ready), 0);
      chk("bp_shift_en", 32'(shift_en), 0);
      chk("bp_mac_ce", 32'(mac_ce), 0);
      chk("bp_m_valid", 32'(m_valid), 1);
      chk("bp_m_last", 32'(m_last), 32'(held_last));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(db);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("f1_outputs", 32'(out_total - ob), 12);
    chk("f1_done", 32'(done_total - db), 1);

    // Frame 2: reset asserted while flushing
    do_start();
    load_kernel(10);
    s_valid = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
        @(negedge clk);
        seen = pad_in;
      end
      chk("flush_seen", 32'(seen), 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst_vals("async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame 3: clean frame after reset
    ob = out_total;
    db = done_total;
    do_start();
    load_kernel(20);
    s_valid = 1'b1;
    wait_done(db);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("f3_outputs", 32'(out_total - ob), 12);
    chk("f3_done", 32'(done_total - db), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
